// File: rtl/fifo_rd_stream_adapter.sv
// Drain stage for sync_fifo: credit-based read issue plus a 2-entry
// skid buffer feeding a valid/ready stream, with a delivered-word count.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  head_q;
  logic [1:0]            buf_cnt;
  logic                  inflight_q;
  logic                  pop;
  logic                  tail;
  logic [1:0]            cnt_nxt;

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = mem[head_q];
  assign pop     = m_valid && m_ready;

  // Tail is the slot after head when one word is held, else head itself.
  assign tail    = head_q ^ (buf_cnt == 2'd1);
  assign cnt_nxt = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};

  // A read is issued only if its word is guaranteed a slot on landing.
  assign fifo_rd_en = rstn && !clr && !fifo_empty
                   && (cnt_nxt < 2'd2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      head_q     <= 1'b0;
      buf_cnt    <= 2'd0;
      inflight_q <= 1'b0;
      word_cnt   <= '0;
    end else if (clr) begin
      head_q     <= 1'b0;
      buf_cnt    <= 2'd0;
      inflight_q <= 1'b0;
      word_cnt   <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      buf_cnt    <= cnt_nxt;
      if (pop) begin
        head_q   <= ~head_q;
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
      if (inflight_q) begin
        mem[tail] <= fifo_dout;
      end
    end
  end

endmodule
